// File: rtl/adder_arbiter.sv
// Round-robin arbiter that lets two valid/ready requesters share one flag-generating adder.
// Each transaction takes three states (accept, execute, respond) and ends on a tagged, backpressured response port.
module adder_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_z,
  output logic [4:0]       rsp_flags,
  input  logic             rsp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_z_q, rsp_z_d;
  logic [4:0]       rsp_flags_q, rsp_flags_d;

  logic [WIDTH-1:0] add_z;
  logic             add_carry, add_zero, add_sign, add_parity, add_overflow;
  logic             grant0, grant1;

  Adder u_adder (
    .A        (op_a_q),
    .B        (op_b_q),
    .Z        (add_z),
    .carry    (add_carry),
    .zero     (add_zero),
    .sign     (add_sign),
    .parity   (add_parity),
    .overflow (add_overflow)
  );

  // Readies are gated by rst so nothing can be accepted while reset is held.
  always_comb begin
    grant0     = req0_valid & (~ptr_q | ~req1_valid);
    grant1     = req1_valid & ( ptr_q | ~req0_valid);
    req0_ready = (state_q == IDLE) & grant0 & ~rst;
    req1_ready = (state_q == IDLE) & grant1 & ~rst;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_z_d     = rsp_z_q;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          op_a_d  = req0_a;
          op_b_d  = req0_b;
          id_d    = 1'b0;
          ptr_d   = 1'b1;
          state_d = EXEC;
        end else if (req1_ready) begin
          op_a_d  = req1_a;
          op_b_d  = req1_b;
          id_d    = 1'b1;
          ptr_d   = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_z_d     = add_z;
        rsp_flags_d = {add_carry, add_zero, add_sign, add_parity, add_overflow};
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_z_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_z_q     <= rsp_z_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  always_comb begin
    rsp_valid = rsp_valid_q;
    rsp_id    = rsp_id_q;
    rsp_z     = rsp_z_q;
    rsp_flags = rsp_flags_q;
    busy      = (state_q != IDLE);
  end

endmodule

// 16-bit adder producing sum plus carry, zero, sign, even-parity and signed-overflow flags.
module Adder (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Z,
  output logic        carry,
  output logic        zero,
  output logic        sign,
  output logic        parity,
  output logic        overflow
);

  logic [16:0] sum;

  always_comb begin
    sum      = {1'b0, A} + {1'b0, B};
    Z        = sum[15:0];
    carry    = sum[16];
    zero     = (sum[15:0] == '0);
    sign     = sum[15];
    parity   = ~^sum[15:0];
    overflow = (A[15] == B[15]) && (sum[15] != A[15]);
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboarded bench for adder_arbiter: expected responses are queued at stimulus time and
// compared when the response port fires.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_ready, busy;
  logic [15:0] rsp_z;
  logic [4:0]  rsp_flags;

  int          pass_cnt  = 0;
  int          check_cnt = 0;
  int          cyc       = 0;
  logic [21:0] exp_q[$];
  logic [21:0] mon_got, mon_exp;

  adder_arbiter #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_z      (rsp_z),
    .rsp_flags  (rsp_flags),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

  // Reference model: {id, carry, zero, sign, parity, overflow, z}
  function automatic logic [21:0] model(input logic id, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] z;
    logic [4:0]  f;
    s = {1'b0, a} + {1'b0, b};
    z = s[15:0];
    f[4] = s[16];
    f[3] = (z == 16'h0000);
    f[2] = z[15];
    f[1] = ~^z;
    f[0] = (a[15] == b[15]) && (z[15] != a[15]);
    return {id, f, z};
  endfunction

  // Scoreboard: a response is consumed at the edge following a negedge where valid & ready.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      mon_got   = {rsp_id, rsp_flags, rsp_z};
      check_cnt = check_cnt + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL rsp_unexpected got=%h expected=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp)
          $display("FAIL rsp_data got=%h expected=%h", mon_got, mon_exp);
        else
          pass_cnt = pass_cnt + 1;
      end
    end
  end

  task automatic send(input logic id, input logic [15:0] a, input logic [15:0] b, output bit ok);
    @(posedge clk); #1;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!ok) begin
      check_cnt = check_cnt + 1;
      $display("FAIL send_timeout id=%0d ready=0 expected ready=1", id);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    #1;
    check_cnt = check_cnt + 1;
    if (exp_q.size() != 0)
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    else
      pass_cnt = pass_cnt + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0001;
    req1_valid = 1'b1; req1_a = 16'h4321; req1_b = 16'h0002;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cnt = check_cnt + 1;
    if ({req0_ready, req1_ready, busy, rsp_valid, rsp_id} !== 5'b0)
      $display("FAIL reset_ctrl got=%b expected=00000", {req0_ready, req1_ready, busy, rsp_valid, rsp_id});
    else pass_cnt = pass_cnt + 1;
    check_cnt = check_cnt + 1;
    if ({rsp_flags, rsp_z} !== 21'h0)
      $display("FAIL reset_data got=%h expected=0", {rsp_flags, rsp_z});
    else pass_cnt = pass_cnt + 1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_cnt = check_cnt + 1;
    if (busy !== 1'b0) $display("FAIL idle_no_req busy=%b expected=0", busy);
    else pass_cnt = pass_cnt + 1;
  endtask

  task automatic test_single(input logic id, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] ez, input logic [4:0] ef);
    bit ok;
    exp_q.push_back({id, ef, ez});
    rsp_ready = 1'b1;
    send(id, a, b, ok);
    @(negedge clk);
    check_cnt = check_cnt + 1;
    if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b0100)
      $display("FAIL exec_state got=%b expected=0100", {rsp_valid, busy, req0_ready, req1_ready});
    else pass_cnt = pass_cnt + 1;
    @(negedge clk);
    check_cnt = check_cnt + 1;
    if (rsp_valid !== 1'b1) $display("FAIL rsp_latency rsp_valid=%b expected=1", rsp_valid);
    else pass_cnt = pass_cnt + 1;
    @(negedge clk);
    check_cnt = check_cnt + 1;
    if ({rsp_valid, busy} !== 2'b00)
      $display("FAIL consumed got=%b expected=00", {rsp_valid, busy});
    else pass_cnt = pass_cnt + 1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] a0[4], b0[4], a1[4], b1[4];
    int          i0, i1, last_acc;
    logic        g0, g1, exp_id;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a0[k] = 16'($urandom); b0[k] = 16'($urandom);
      a1[k] = 16'($urandom); b1[k] = 16'($urandom);
    end
    i0 = 0; i1 = 0; last_acc = -1; exp_id = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = a0[0]; req0_b = b0[0];
    req1_valid = 1'b1; req1_a = a1[0]; req1_b = b1[0];
    for (int c = 0; c < 60 && (i0 < 4 || i1 < 4); c++) begin
      @(negedge clk);
      g0 = req0_ready;
      g1 = req1_ready;
      check_cnt = check_cnt + 1;
      if (g0 && g1) $display("FAIL both_ready got=11 expected=at most one");
      else pass_cnt = pass_cnt + 1;
      if (g0 || g1) begin
        check_cnt = check_cnt + 1;
        if (g1 !== exp_id) $display("FAIL grant_order got=%0d expected=%0d", g1, exp_id);
        else pass_cnt = pass_cnt + 1;
        exp_id = ~exp_id;
        if (last_acc >= 0) begin
          check_cnt = check_cnt + 1;
          if (cyc - last_acc != 3) $display("FAIL accept_spacing got=%0d expected=3", cyc - last_acc);
          else pass_cnt = pass_cnt + 1;
        end
        last_acc = cyc;
        if (g1) exp_q.push_back(model(1'b1, a1[i1], b1[i1]));
        else    exp_q.push_back(model(1'b0, a0[i0], b0[i0]));
      end
      @(posedge clk); #1;
      if (g0) begin
        i0 = i0 + 1;
        if (i0 < 4) begin req0_a = a0[i0]; req0_b = b0[i0]; end
        else req0_valid = 1'b0;
      end
      if (g1) begin
        i1 = i1 + 1;
        if (i1 < 4) begin req1_a = a1[i1]; req1_b = b1[i1]; end
        else req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (i0 < 4 || i1 < 4) begin
      check_cnt = check_cnt + 1;
      $display("FAIL b2b_timeout accepted=%0d/%0d expected=4/4", i0, i1);
    end
    drain();
  endtask

  task automatic test_backpressure();
    bit          ok;
    logic [21:0] e, snap;
    rsp_ready = 1'b0;
    e = model(1'b1, 16'h1234, 16'h8765);
    exp_q.push_back(e);
    send(1'b1, 16'h1234, 16'h8765, ok);
    @(negedge clk);
    @(negedge clk);
    snap = {rsp_id, rsp_flags, rsp_z};
    check_cnt = check_cnt + 1;
    if (rsp_valid !== 1'b1 || snap !== e)
      $display("FAIL bp_first got=%b/%h expected=1/%h", rsp_valid, snap, e);
    else pass_cnt = pass_cnt + 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001;
      req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0002;
      @(negedge clk);
      check_cnt = check_cnt + 1;
      if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b1100)
        $display("FAIL bp_hold_ctrl got=%b expected=1100", {rsp_valid, busy, req0_ready, req1_ready});
      else pass_cnt = pass_cnt + 1;
      check_cnt = check_cnt + 1;
      if ({rsp_id, rsp_flags, rsp_z} !== snap)
        $display("FAIL bp_hold_data got=%h expected=%h", {rsp_id, rsp_flags, rsp_z}, snap);
      else pass_cnt = pass_cnt + 1;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_cnt = check_cnt + 1;
    if ({rsp_valid, busy} !== 2'b00)
      $display("FAIL bp_release got=%b expected=00", {rsp_valid, busy});
    else pass_cnt = pass_cnt + 1;
    drain();
  endtask

  task automatic test_reset_mid();
    bit ok;
    rsp_ready = 1'b0;
    send(1'b0, 16'h1111, 16'h2222, ok);
    req1_valid = 1'b1; req1_a = 16'h0003; req1_b = 16'h0004;
    #1 rst = 1'b1;
    #1;
    check_cnt = check_cnt + 1;
    if ({req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_flags, rsp_z} !== 26'h0)
      $display("FAIL rst_exec got=%h expected=0", {req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_flags, rsp_z});
    else pass_cnt = pass_cnt + 1;
    @(negedge clk);
    req1_valid = 1'b0;
    rst = 1'b0;
    send(1'b1, 16'hF0F0, 16'h0F0F, ok);
    @(negedge clk);
    @(negedge clk);
    check_cnt = check_cnt + 1;
    if ({rsp_valid, rsp_id, busy} !== 3'b111)
      $display("FAIL pre_rst_resp got=%b expected=111", {rsp_valid, rsp_id, busy});
    else pass_cnt = pass_cnt + 1;
    #1 rst = 1'b1;
    #1;
    check_cnt = check_cnt + 1;
    if ({req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_flags, rsp_z} !== 26'h0)
      $display("FAIL rst_resp got=%h expected=0", {req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_flags, rsp_z});
    else pass_cnt = pass_cnt + 1;
    req0_valid = 1'b1; req0_a = 16'h7FFF; req0_b = 16'h0001;
    req1_valid = 1'b1; req1_a = 16'h0000; req1_b = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_cnt = check_cnt + 1;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL post_rst_grant got=%b expected=10", {req0_ready, req1_ready});
    else pass_cnt = pass_cnt + 1;
    exp_q.push_back(model(1'b0, 16'h7FFF, 16'h0001));
    exp_q.push_back(model(1'b1, 16'h0000, 16'h0000));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req1_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    if (!ok) begin
      check_cnt = check_cnt + 1;
      $display("FAIL post_rst_req1 ready=0 expected=1");
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    test_reset();
    test_single(1'b0, 16'h8FFF, 16'h8000, 16'h0FFF, 5'b10011);
    test_single(1'b1, 16'hFFFE, 16'h0002, 16'h0000, 5'b11010);
    test_single(1'b0, 16'hAAAA, 16'h5555, 16'hFFFF, 5'b00110);
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
